// File: rtl/rf_write_buffer.sv
// Register file write buffer: an in-order FIFO of writeback requests drained one per
// cycle onto the RF write port, with youngest-wins forwarding of pending values to two read selects.
module rf_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_wsel,
  input  logic [31:0] in_wdat,
  input  logic        rf_hold,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat,
  input  logic [4:0]  rsel1,
  input  logic [4:0]  rsel2,
  output logic        hit1,
  output logic        hit2,
  output logic [31:0] fwd1,
  output logic [31:0] fwd2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [4:0]       wsel_mem [DEPTH];
  logic [31:0]      wdat_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic accept;
  logic store;
  logic deq;

  // Ready looks only at the registered count, so a full buffer stays closed even on a dequeue cycle.
  assign in_ready = (count_reg != FULL_CNT);
  assign accept   = in_valid && in_ready;
  // Writes to r0 complete the handshake but are dropped here.
  assign store    = accept && (in_wsel != 5'd0);

  assign WEN  = (count_reg != '0);
  assign deq  = WEN && !rf_hold;
  assign wsel = WEN ? wsel_mem[head_reg] : 5'd0;
  assign wdat = WEN ? wdat_mem[head_reg] : 32'd0;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (deq) begin
      head_next = head_reg + PTR_W'(1);
    end
    if (store) begin
      tail_next = tail_reg + PTR_W'(1);
    end
    case ({store, deq})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Tail can equal head only when empty (no dequeue) or full (no store), so set and clear never collide.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_comb begin
        valid_next[gi] = valid_reg[gi];
        if (deq && (head_reg == PTR_W'(gi))) begin
          valid_next[gi] = 1'b0;
        end
        if (store && (tail_reg == PTR_W'(gi))) begin
          valid_next[gi] = 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (store) begin
      wsel_mem[tail_reg] <= in_wsel;
      wdat_mem[tail_reg] <= in_wdat;
    end
  end

  // Scan oldest to youngest so the last match (youngest) overrides earlier ones.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
      logic [4:0]  rsel_l;
      logic        hit_l;
      logic [31:0] fwd_l;

      assign rsel_l = (gi == 0) ? rsel1 : rsel2;

      always_comb begin
        hit_l = 1'b0;
        fwd_l = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
          if (valid_reg[head_reg + PTR_W'(k)] && (rsel_l != 5'd0) &&
              (wsel_mem[head_reg + PTR_W'(k)] == rsel_l)) begin
            hit_l = 1'b1;
            fwd_l = wdat_mem[head_reg + PTR_W'(k)];
          end
        end
      end
    end
  endgenerate

  assign hit1 = g_lookup[0].hit_l;
  assign fwd1 = g_lookup[0].fwd_l;
  assign hit2 = g_lookup[1].hit_l;
  assign fwd2 = g_lookup[1].fwd_l;

endmodule

// File: tb/tb_rf_write_buffer.sv
// Bench for rf_write_buffer: a queue-based reference model feeds an issue scoreboard that a
// negedge monitor drains whenever the DUT presents a write it will commit.
module tb_rf_write_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wsel;
  logic [31:0] in_wdat;
  logic        rf_hold;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [4:0]  rsel1, rsel2;
  logic        hit1, hit2;
  logic [31:0] fwd1, fwd2;

  rf_write_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_wsel(in_wsel), .in_wdat(in_wdat),
    .rf_hold(rf_hold), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel1(rsel1), .rsel2(rsel2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  ws;
    logic [31:0] wd;
  } ent_t;

  ent_t pend[$];   // reference buffer contents, oldest first
  ent_t exp_q[$];  // scoreboard of writes still expected on the port

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lookup(input logic [4:0] r, output logic h, output logic [31:0] f);
    h = 1'b0;
    f = 32'd0;
    for (int k = 0; k < pend.size(); k++) begin
      if (r != 5'd0 && pend[k].ws == r) begin
        h = 1'b1;
        f = pend[k].wd;
      end
    end
  endtask

  // Reference model: a bounded in-order queue updated on each rising edge.
  always @(posedge CLK) begin : model
    bit acc, dq;
    ent_t e;
    if (!nRST) begin
      pend.delete();
      exp_q.delete();
    end else begin
      acc = in_valid && (pend.size() != DEPTH);
      dq  = (pend.size() != 0) && !rf_hold;
      if (dq) pend.delete(0);
      if (acc && in_wsel != 5'd0) begin
        e.ws = in_wsel;
        e.wd = in_wdat;
        pend.push_back(e);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares every output against the model, pops the scoreboard on committed writes.
  always @(negedge CLK) begin : monitor
    logic        eh;
    logic [31:0] ef;
    if (mon_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, pend.size() != DEPTH});
      chk("WEN", {31'd0, WEN}, {31'd0, pend.size() != 0});
      if (WEN === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {27'd0, wsel}, 32'd0);
        end else begin
          chk("wsel", {27'd0, wsel}, {27'd0, exp_q[0].ws});
          chk("wdat", wdat, exp_q[0].wd);
          if (!rf_hold && nRST) begin
            $display("write r%0d = %08h", wsel, wdat);
            exp_q.delete(0);
          end
        end
      end else begin
        chk("wsel_idle", {27'd0, wsel}, 32'd0);
        chk("wdat_idle", wdat, 32'd0);
      end
      lookup(rsel1, eh, ef);
      chk("hit1", {31'd0, hit1}, {31'd0, eh});
      chk("fwd1", fwd1, ef);
      lookup(rsel2, eh, ef);
      chk("hit2", {31'd0, hit2}, {31'd0, eh});
      chk("fwd2", fwd2, ef);
    end
  end

  task automatic drive(input logic v, input logic [4:0] ws, input logic [31:0] wd,
                       input logic hold, input logic [4:0] r1, input logic [4:0] r2);
    in_valid = v;
    in_wsel  = ws;
    in_wdat  = wd;
    rf_hold  = hold;
    rsel1    = r1;
    rsel2    = r2;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input logic hold, input logic [4:0] r1, input logic [4:0] r2);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, hold, r1, r2);
  endtask

  initial begin
    nRST = 1'b0;
    idle(2, 1'b0, 5'd0, 5'd0);
    nRST = 1'b1;
    mon_en = 1'b1;

    // Single write, visible next cycle, gone the cycle after
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    idle(3, 1'b0, 5'd5, 5'd0);

    // Fill under hold, one refused extra, then drain
    for (int i = 1; i <= 4; i++) drive(1'b1, 5'(i), 32'(i * 32'h11), 1'b1, 5'd1, 5'd4);
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd2);
    idle(2, 1'b1, 5'd3, 5'd1);
    idle(6, 1'b0, 5'd2, 5'd4);

    // Youngest wins
    drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd0, 5'd7);
    drive(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 5'd7);
    idle(2, 1'b1, 5'd7, 5'd7);
    idle(4, 1'b0, 5'd7, 5'd7);

    // Register zero
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    idle(2, 1'b0, 5'd0, 5'd0);

    // Streaming with wrap, then toggled hold
    for (int i = 0; i < 10; i++) drive(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 5'(i), 5'(i + 1));
    for (int i = 0; i < 10; i++) drive(1'b1, 5'(i + 11), 32'h200 + 32'(i), 1'(i % 2), 5'(i + 10), 5'(i + 11));
    idle(8, 1'b0, 5'd0, 5'd0);

    // Reset with three pending
    for (int i = 0; i < 3; i++) drive(1'b1, 5'(20 + i), 32'h300 + 32'(i), 1'b1, 5'd20, 5'd22);
    nRST = 1'b0;
    idle(1, 1'b1, 5'd20, 5'd22);
    nRST = 1'b1;
    idle(3, 1'b0, 5'd20, 5'd22);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      nRST = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    nRST = 1'b1;
    idle(DEPTH + 4, 1'b0, 5'd0, 5'd0);

    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_buffer.md
# rf_write_buffer

Write-side initiator for the CPU register file. It queues writeback requests (register index and data) in a small in-order FIFO and drains one entry per cycle onto the register file write port (WEN, wsel, wdat). While writes are pending, it forwards the youngest queued value to the two read selects, so readers never see stale data. It sits between the writeback stage and the register file, and absorbs cycles where the write port is held.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- in_valid  in  1  writeback request present.
- in_ready  out  1  buffer can accept a request this cycle.
- in_wsel  in  5  destination register index.
- in_wdat  in  32  write data (word_t).
- rf_hold  in  1  write port unavailable this cycle; head is not dequeued.
- WEN  out  1  register file write enable.
- wsel  out  5  register file write index.
- wdat  out  32  register file write data.
- rsel1, rsel2  in  5  read selects under lookup.
- hit1, hit2  out  1  a pending write matches rselN.
- fwd1, fwd2  out  32  pending data for rselN; 0 when there is no hit.

## Operation
- State:
  - DEPTH entries of {wsel, wdat, valid}.
  - Head pointer and tail pointer, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count, clog2(DEPTH+1) bits.
- Enqueue occurs when in_valid && in_ready. The entry is written at the tail, tail advances, and count increments.
- Requests with in_wsel == 0 are accepted (handshake completes) but not stored. Pointers and count are unchanged and no write is ever issued.
- in_ready = (count != DEPTH). It depends only on registered state. When the buffer is full, a same-cycle dequeue does not open a slot.
- Write port outputs:
  - WEN = (count != 0).
  - wsel and wdat are the head entry's fields when WEN = 1, and 0 otherwise.
- Dequeue occurs when WEN && !rf_hold. Head advances and count decrements.
- WEN stays high while rf_hold is asserted. The register file consumes the write only on a non-held cycle, so the head must remain stable while held.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Forwarding:
  - Lookup is combinational over all valid stored entries, including the head.
  - If several entries match rselN, the youngest (closest to the tail) wins.
  - rselN == 0 never hits.
  - The input port is not searched. A request is visible to lookup from the cycle after it is accepted.
- Reset (nRST low at a rising edge):
  - count, head, and tail are cleared and all valid bits are cleared.
  - This applies mid-operation too: pending writes are discarded and never issued.
  - Entry data need not be cleared.

## Timing
- Reset values: in_ready=1, WEN=0, wsel=0, wdat=0, hit1=hit2=0, fwd1=fwd2=0.
- Enqueue-to-WEN latency is 1 cycle. A request accepted at edge t drives WEN in cycle t+1. There is no same-cycle pass-through.
- Throughput is 1 write per cycle sustained when rf_hold is low.
- All outputs are combinational from registered state plus rsel1, rsel2, and rf_hold. in_ready has no dependency on in_valid.
- A dequeued entry stops forwarding in the cycle after its dequeue edge. The register file holds the value by then because its write lands on the preceding falling edge.

## Test plan
- Reset then single write:
  - Stimulus: after reset, enqueue {wsel=5, wdat=0xDEADBEEF}.
  - Required response: next cycle WEN=1, wsel=5, wdat=0xDEADBEEF, and hit1=1 for rsel1=5. The following cycle WEN=0 and hit1=0.
- Fill with hold:
  - Stimulus: hold rf_hold=1 and enqueue 4 writes to r1..r4 with data 0x11..0x44.
  - Required response: in_ready drops after the 4th accept, and WEN=1 with wsel=1 stays stable. After rf_hold is released, r1..r4 drain on 4 consecutive cycles in order.
- Youngest-wins forwarding:
  - Stimulus: with hold asserted, enqueue r7=0xA then r7=0xB.
  - Required response: rsel2=7 gives hit2=1, fwd2=0xB. Both writes are still issued in order, 0xA then 0xB.
- Register zero:
  - Stimulus: enqueue {wsel=0, wdat=0xFFFFFFFF}.
  - Required response: in_ready handshake completes, count stays 0, WEN never rises, and rsel1=0 gives hit1=0.
- Wrap and simultaneous ops:
  - Stimulus: stream 10 back-to-back writes with rf_hold=0, then toggle rf_hold every cycle.
  - Required response: no drops, no duplicates, issue order matches enqueue order, and count never exceeds DEPTH.
- Reset mid-operation:
  - Stimulus: with 3 entries pending, assert nRST=0 for one edge.
  - Required response: next cycle WEN=0, in_ready=1, and no hits. The discarded entries never appear on wsel.
